// File: rtl/serial_operand_feeder.sv
// serial_operand_feeder
// Accepts one parallel operand pair through a valid/ready handshake and streams
// both operands LSB-first, one bit per enabled cycle, followed by PAD_W padding
// cycles so the downstream serial-multiplier chain can drain its product.
//
// Handshake: an operand pair transfers on a rising edge where i_valid and
// o_ready are both high; the source holds i_a/i_b/i_valid until that edge.
// o_ready is high in IDLE and on the final stream cycle when i_en=1, so a new
// stream can follow the previous one with no bubble.
//
// Optional build macro SERIAL_FEEDER_SIGN_EXT_EN: padding cycles carry each
// operand's MSB (captured at acceptance) instead of 0, which yields a
// two's-complement sign-extended stream.
module serial_operand_feeder #(
  parameter int DATA_W = 8,
  parameter int PAD_W  = 8
) (
  input  logic              i_clk,
  input  logic              i_arstn,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic              i_en,
  output logic              o_valid,
  output logic              o_a,
  output logic              o_b,
  output logic              o_first,
  output logic              o_last,
  output logic              o_busy
);

  localparam int CW = $clog2(DATA_W + PAD_W + 1);
  localparam logic [CW-1:0] SHIFT_END = CW'(DATA_W - 1);
  localparam logic [CW-1:0] LAST_CNT  = CW'(DATA_W + PAD_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAD   = 2'd2
  } state_t;

  // Current FSM state, kept as a named signal so checkers can bind to it.
  state_t            state;
  state_t            state_n;
  logic [DATA_W-1:0] sa;
  logic [DATA_W-1:0] sa_n;
  logic [DATA_W-1:0] sb;
  logic [DATA_W-1:0] sb_n;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_n;
  logic              pad_a;
  logic              pad_b;
  logic              ready_int;
  logic              accept;
  logic              done;

`ifdef SERIAL_FEEDER_SIGN_EXT_EN
  logic pad_a_n;
  logic pad_b_n;

  // Operand MSBs captured at acceptance drive the padding bits.
  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      pad_a <= 1'b0;
      pad_b <= 1'b0;
    end else begin
      pad_a <= pad_a_n;
      pad_b <= pad_b_n;
    end
  end

  // Capture new sign bits whenever a pair is accepted.
  always_comb begin
    pad_a_n = pad_a;
    pad_b_n = pad_b;
    if (accept) begin
      pad_a_n = i_a[DATA_W-1];
      pad_b_n = i_b[DATA_W-1];
    end
  end
`else
  assign pad_a = 1'b0;
  assign pad_b = 1'b0;
`endif

  // State, shift registers and bit counter.
  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      sa    <= sa_n;
      sb    <= sb_n;
      cnt   <= cnt_n;
    end
  end

  // Stream outputs, derived from state and counter; they hold during a stall
  // because the registers feeding them hold.
  always_comb begin
    o_busy    = (state != IDLE);
    o_last    = o_busy && (cnt == LAST_CNT);
    o_first   = (state == SHIFT) && (cnt == '0);
    o_valid   = o_busy && i_en;
    ready_int = (state == IDLE) || (o_last && i_en);
    o_ready   = i_arstn && ready_int;
    accept    = i_valid && ready_int;
    o_a       = 1'b0;
    o_b       = 1'b0;
    case (state)
      SHIFT: begin
        o_a = sa[0];
        o_b = sb[0];
      end
      PAD: begin
        o_a = pad_a;
        o_b = pad_b;
      end
      default: begin
        o_a = 1'b0;
        o_b = 1'b0;
      end
    endcase
  end

  // Next-state logic: advance on i_en, and at end of stream either start the
  // next accepted pair immediately or fall back to IDLE.
  always_comb begin
    state_n = state;
    sa_n    = sa;
    sb_n    = sb;
    cnt_n   = cnt;
    done    = 1'b0;
    case (state)
      IDLE: begin
        done = 1'b0;
      end
      SHIFT: begin
        if (i_en) begin
          sa_n  = {1'b0, sa[DATA_W-1:1]};
          sb_n  = {1'b0, sb[DATA_W-1:1]};
          cnt_n = cnt + CW'(1);
          if (cnt == LAST_CNT) begin
            // Only reachable here when there are no padding cycles.
            done = 1'b1;
          end else if (cnt == SHIFT_END) begin
            state_n = PAD;
          end
        end
      end
      PAD: begin
        if (i_en) begin
          cnt_n = cnt + CW'(1);
          if (cnt == LAST_CNT) begin
            done = 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    if (done) begin
      state_n = IDLE;
      cnt_n   = '0;
    end
    if (accept) begin
      state_n = SHIFT;
      sa_n    = i_a;
      sb_n    = i_b;
      cnt_n   = '0;
    end
  end

endmodule

// File: tb/tb_serial_operand_feeder.sv
// Testbench for serial_operand_feeder: one instance with DATA_W=4/PAD_W=4 and
// one with DATA_W=4/PAD_W=0. A stream-level reference model expands every
// accepted pair into its list of expected stream cycles and pops one entry per
// enabled cycle.
module tb_serial_operand_feeder;

  localparam int DW = 4;

  typedef struct packed {
    logic a;
    logic b;
    logic first;
    logic last;
  } item_t;

  logic          clk;
  logic          arstn;
  logic          en;
  logic          valid4, valid0;
  logic [DW-1:0] a4, b4, a0, b0;
  logic          ready4, vld4, oa4, ob4, first4, last4, busy4;
  logic          ready0, vld0, oa0, ob0, first0, last0, busy0;

  item_t q4[$];
  item_t q0[$];
  int    checks;
  int    failures;

  serial_operand_feeder #(.DATA_W(DW), .PAD_W(4)) dut (
    .i_clk(clk), .i_arstn(arstn), .i_valid(valid4), .o_ready(ready4),
    .i_a(a4), .i_b(b4), .i_en(en), .o_valid(vld4), .o_a(oa4), .o_b(ob4),
    .o_first(first4), .o_last(last4), .o_busy(busy4)
  );

  serial_operand_feeder #(.DATA_W(DW), .PAD_W(0)) dut0 (
    .i_clk(clk), .i_arstn(arstn), .i_valid(valid0), .o_ready(ready0),
    .i_a(a0), .i_b(b0), .i_en(en), .o_valid(vld0), .o_a(oa0), .o_b(ob0),
    .o_first(first0), .o_last(last0), .o_busy(busy0)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s t=%0t observed=%b expected=%b", tag, $time, obs, exp);
    end
  endtask

  // One stream cycle of an operand pair at position i.
  function automatic item_t mk(input logic [DW-1:0] a, input logic [DW-1:0] b,
                               input int i, input int pad_w);
    item_t it;
    logic  pa, pb;
`ifdef SERIAL_FEEDER_SIGN_EXT_EN
    pa = a[DW-1];
    pb = b[DW-1];
`else
    pa = 1'b0;
    pb = 1'b0;
`endif
    it.a     = (i < DW) ? a[i] : pa;
    it.b     = (i < DW) ? b[i] : pb;
    it.first = (i == 0);
    it.last  = (i == DW + pad_w - 1);
    return it;
  endfunction

  // Compare both DUTs against the model's current front entry.
  task automatic compare_all();
    logic  bz;
    item_t f;
    bz = (q4.size() > 0);
    f  = bz ? q4[0] : '0;
    chk("d4_busy", busy4, bz);
    chk("d4_valid", vld4, bz & en);
    chk("d4_a", oa4, f.a);
    chk("d4_b", ob4, f.b);
    chk("d4_first", first4, f.first);
    chk("d4_last", last4, f.last);
    chk("d4_ready", ready4, arstn & (!bz | (f.last & en)));
    bz = (q0.size() > 0);
    f  = bz ? q0[0] : '0;
    chk("d0_busy", busy0, bz);
    chk("d0_valid", vld0, bz & en);
    chk("d0_a", oa0, f.a);
    chk("d0_b", ob0, f.b);
    chk("d0_first", first0, f.first);
    chk("d0_last", last0, f.last);
    chk("d0_ready", ready0, arstn & (!bz | (f.last & en)));
  endtask

  // One clock: check mid-cycle, advance the model at the edge, then release
  // any accepted source.
  task automatic cycle();
    logic r4, r0, acc4, acc0;
    @(negedge clk);
    compare_all();
    @(posedge clk);
    if (!arstn) begin
      q4.delete();
      q0.delete();
      acc4 = 1'b0;
      acc0 = 1'b0;
    end else begin
      r4   = (q4.size() == 0) || (q4[0].last && en);
      r0   = (q0.size() == 0) || (q0[0].last && en);
      acc4 = valid4 && r4;
      acc0 = valid0 && r0;
      if (en && q4.size() > 0) void'(q4.pop_front());
      if (en && q0.size() > 0) void'(q0.pop_front());
      if (acc4) for (int i = 0; i < DW + 4; i++) q4.push_back(mk(a4, b4, i, 4));
      if (acc0) for (int i = 0; i < DW; i++) q0.push_back(mk(a0, b0, i, 0));
    end
    #1;
    if (acc4) valid4 = 1'b0;
    if (acc0) valid0 = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic offer4(input logic [DW-1:0] a, input logic [DW-1:0] b);
    a4 = a; b4 = b; valid4 = 1'b1;
  endtask

  task automatic offer0(input logic [DW-1:0] a, input logic [DW-1:0] b);
    a0 = a; b0 = b; valid0 = 1'b1;
  endtask

  initial begin
    checks = 0; failures = 0;
    arstn = 1'b0; en = 1'b1;
    valid4 = 1'b0; valid0 = 1'b0;
    a4 = '0; b4 = '0; a0 = '0; b0 = '0;

    // Reset state
    #2;
    compare_all();
    @(posedge clk); #1;
    arstn = 1'b1;
    run(2);

    // Single stream A=1011 B=0110, second pair offered two cycles later and
    // held until taken on the final cycle of the first stream.
    offer4(4'b1011, 4'b0110);
    run(3);
    offer4(4'hF, 4'h1);
    run(18);

    // Stall for three cycles mid-stream
    offer4(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    run(3);
    en = 1'b0;
    run(3);
    en = 1'b1;
    run(12);

    // Reset asserted mid-stream aborts at once
    offer4(4'b0111, 4'b1101);
    offer0(4'b0101, 4'b0011);
    run(4);
    arstn = 1'b0;
    valid4 = 1'b0;
    valid0 = 1'b0;
    #1;
    chk("rst_busy", busy4, 1'b0);
    chk("rst_valid", vld4, 1'b0);
    chk("rst_a", oa4, 1'b0);
    chk("rst_last", last4, 1'b0);
    chk("rst0_busy", busy0, 1'b0);
    q4.delete();
    q0.delete();
    run(2);
    arstn = 1'b1;
    run(1);
    offer4(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    run(12);

    // No padding: A=1000 gives exactly four stream cycles
    offer0(4'b1000, 4'($urandom_range(0, 15)));
    run(8);

    // Padding content with a negative operand
    offer4(4'b1010, 4'b0101);
    offer0(4'b1010, 4'b1100);
    run(12);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      if (!valid4 && $urandom_range(0, 2) == 0)
        offer4(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      if (!valid0 && $urandom_range(0, 2) == 0)
        offer0(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      en = ($urandom_range(0, 4) != 0);
      cycle();
    end
    en = 1'b1;
    run(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_operand_feeder.md
Name: serial_operand_feeder

Overview:
- Upstream stage of the serial-multiplier chain. Accepts one pair of parallel operands through a valid/ready handshake.
- Streams both operands out LSB-first, one bit per enabled cycle, on o_a/o_b, followed by PAD_W padding cycles so the downstream 2-bit intermediate blocks can drain the product.
- o_valid drives the chain's i_valid enable; o_first/o_last frame each operand stream for the downstream accumulator.

Parameters:
- DATA_W, 8, operand width in bits (must be >= 2).
- PAD_W, 8, number of padding cycles appended after the data bits (0 allowed).

Ports:
- i_clk  input  1  clock, rising edge.
- i_arstn  input  1  reset, asynchronous, active-low.
- i_valid  input  1  operand pair valid.
- o_ready  output  1  feeder can accept an operand pair this cycle.
- i_a  input  DATA_W  operand A, parallel.
- i_b  input  DATA_W  operand B, parallel.
- i_en  input  1  downstream advance enable; 0 freezes the stream.
- o_valid  output  1  o_a/o_b carry a stream bit this cycle.
- o_a  output  1  serial bit of A (LSB first, then padding).
- o_b  output  1  serial bit of B (LSB first, then padding).
- o_first  output  1  current bit is bit 0 of the stream.
- o_last  output  1  current bit is the final cycle of the stream.
- o_busy  output  1  stream in progress (state != IDLE).

Behaviour:
- Reset is decided as: i_clk clock; i_arstn asynchronous, active-low.
- Reset state is IDLE with the shift registers and counter at 0. Outputs during and after reset:
  - o_valid=0, o_a=0, o_b=0, o_first=0, o_last=0, o_busy=0.
  - o_ready=1 once i_arstn is released.
- Asserting reset mid-stream aborts immediately: the state returns to IDLE and the partial stream is discarded. No o_last is issued.
- State machine: IDLE, SHIFT, PAD.
  - IDLE: o_ready=1. If i_valid, latch i_a/i_b into shift registers sa/sb, clear the counter cnt, and go to SHIFT.
  - SHIFT: o_a=sa[0], o_b=sb[0]. On each edge with i_en=1, shift sa/sb right and increment cnt. At cnt==DATA_W-1 with i_en=1, go to PAD (or to the end-of-stream action if PAD_W==0).
  - PAD: o_a=0, o_b=0. On each edge with i_en=1, increment cnt. At cnt==DATA_W+PAD_W-1 with i_en=1, take the end-of-stream action.
  - End-of-stream action: go to SHIFT with new operands if the handshake completed this cycle; otherwise go to IDLE.
- Derived outputs:
  - o_valid = o_busy & i_en.
  - o_first = SHIFT & cnt==0.
  - o_last = o_busy & cnt==DATA_W+PAD_W-1.
- o_ready=1 in IDLE, and also on the o_last cycle when i_en=1. This allows back-to-back streams with no bubble.
- o_ready=0 in all other cycles. i_valid while o_ready=0 is ignored; the source must hold i_a/i_b/i_valid until accepted.
- Latency: a handshake at edge T gives o_a=A[0] in the cycle after T. The stream length is DATA_W+PAD_W enabled cycles.
- i_en=0 (stall): state, cnt, sa, sb hold; o_valid=0; o_a/o_b/o_first/o_last keep their values. A stall on the o_last cycle deasserts o_ready for that cycle.
- Counter width: $clog2(DATA_W+PAD_W+1). cnt resets to 0 at each new stream and never wraps inside a stream.

Optional Feature:
- Macro: SERIAL_FEEDER_SIGN_EXT_EN.
- Defined: PAD cycles output the operand MSB (A[DATA_W-1], B[DATA_W-1]), captured at acceptance, instead of 0. This gives a two's-complement sign-extended stream.
- Undefined: PAD cycles output 0 (unsigned stream).

Test Plan:
- Single stream (DATA_W=4, PAD_W=4), i_en=1; A=4'b1011, B=4'b0110 accepted at T -> o_a sequence 1,1,0,1,0,0,0,0 and o_b sequence 0,1,1,0,0,0,0,0 on cycles T+1..T+8. o_first at T+1, o_last at T+8, o_ready low T+1..T+7.
- Back-to-back: second pair A=4'hF, B=4'h1 held valid from T+2 -> accepted on the o_last cycle T+8. o_a=1 at T+9 with o_first=1, no bubble.
- Stall: i_en=0 during cycles T+3..T+5 -> o_valid=0 and outputs frozen for those cycles. The stream resumes with bit 2; o_last moves to T+11.
- Reset mid-stream: deassert i_arstn at T+4 -> same cycle o_busy=0, o_valid=0, o_a=0. After release, o_ready=1 and a new pair streams correctly.
- PAD_W=0, A=4'b1000 -> exactly 4 valid cycles with o_a=0,0,0,1, and o_last on the fourth.
- With SERIAL_FEEDER_SIGN_EXT_EN, A=4'b1010 -> padding cycles o_a=1,1,1,1. Without the macro -> padding 0,0,0,0.
